// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: time-multiplexes a 3-digit BCD value onto a 4-digit common-anode seven-segment display
// Ports: clk/rst_n clock and async active-low reset; bcd {hundreds,tens,ones};
//        blank_en leading-zero suppression; blink whole-display blink;
//        an anodes (active low, an[0]=ones); seg {g..a} active low; dp tied off.
module bcd_display_scanner #(
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD        = 4,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] bcd,
  input  logic        blank_en,
  input  logic        blink,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [PW-1:0] r_pre;
  logic [1:0]    r_idx;
  logic [11:0]   r_shadow;
  logic [FW-1:0] r_frame;
  logic          r_phase;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          w_tick, w_fend, w_blank, w_on;
  logic [3:0]    w_digit;
  logic [6:0]    w_dec;
  assign w_tick  = r_pre == PW'(REFRESH_DIV - 1);
  assign w_fend  = w_tick && r_idx == 2'd3;
  assign w_digit = r_idx == 2'd0 ? r_shadow[3:0] : r_idx == 2'd1 ? r_shadow[7:4] : r_shadow[11:8];
  // a non-BCD hundreds nibble is non-zero, so it never triggers blanking
  assign w_blank = blank_en && ((r_idx == 2'd2 && r_shadow[11:8] == 4'd0) ||
                                (r_idx == 2'd1 && r_shadow[11:4] == 8'd0));
  assign w_on    = r_pre >= PW'(GUARD) && r_idx != 2'd3 && !w_blank && !(blink && r_phase);
  always_comb begin
    w_dec = 7'b0111111;
    case (w_digit)
      4'd0: w_dec = 7'b1000000;
      4'd1: w_dec = 7'b1111001;
      4'd2: w_dec = 7'b0100100;
      4'd3: w_dec = 7'b0110000;
      4'd4: w_dec = 7'b0011001;
      4'd5: w_dec = 7'b0010010;
      4'd6: w_dec = 7'b0000010;
      4'd7: w_dec = 7'b1111000;
      4'd8: w_dec = 7'b0000000;
      4'd9: w_dec = 7'b0010000;
      default: w_dec = 7'b0111111;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre    <= '0;
      r_idx    <= 2'd0;
      r_shadow <= 12'h000;
      r_frame  <= '0;
      r_phase  <= 1'b0;
      r_an     <= 4'b1111;
      r_seg    <= 7'b1111111;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      r_idx <= w_tick ? r_idx + 2'd1 : r_idx;
      // capture only at frame end so a frame never mixes digits of two values
      r_shadow <= w_fend ? bcd : r_shadow;
      if (!blink) begin
        r_frame <= '0;
        r_phase <= 1'b0;
      end else if (w_fend) begin
        r_frame <= r_frame == FW'(BLINK_FRAMES - 1) ? '0 : r_frame + 1'b1;
        r_phase <= r_frame == FW'(BLINK_FRAMES - 1) ? ~r_phase : r_phase;
      end
      r_an  <= w_on ? ~(4'b0001 << r_idx) : 4'b1111;
      r_seg <= w_on ? w_dec : 7'b1111111;
    end
  end
  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = 1'b1;
endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: directed and randomized checks of the display scanner against a cycle-count reference model
module tb_bcd_display_scanner;
  localparam int RD = 8;
  localparam int G  = 2;
  localparam int BF = 2;
  localparam int FR = 4 * RD;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] bcd = 12'h000;
  logic        blank_en = 1'b0;
  logic        blink = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  int checks = 0;
  int failures = 0;
  int c = 0;
  int bcnt = 0;
  logic [11:0] sh = 12'h000;
  logic [6:0] dec [16];
  always #5 clk = ~clk;
  bcd_display_scanner #(.REFRESH_DIV(RD), .GUARD(G), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .bcd(bcd), .blank_en(blank_en), .blink(blink),
    .an(an), .seg(seg), .dp(dp)
  );
  function automatic logic [10:0] expect_out();
    int p, i;
    logic [3:0] d;
    bit blank, on;
    p = c % RD;
    i = (c / RD) % 4;
    d = 4'(sh >> (4 * i));
    blank = blank_en && ((i == 2 && sh[11:8] == 4'd0) || (i == 1 && sh[11:8] == 4'd0 && sh[7:4] == 4'd0));
    on = p >= G && i != 3 && !blank && !(blink && (bcnt / BF) % 2 == 1);
    return on ? {~(4'b0001 << i), dec[d]} : {4'hF, 7'h7F};
  endfunction
  task automatic check_out(input string tag, input logic [10:0] e);
    checks++;
    assert ({an, seg, dp} === {e, 1'b1}) else begin
      failures++;
      $error("FAIL %s c=%0d an/seg/dp=%b/%b/%b expected %b/%b/1", tag, c, an, seg, dp, e[10:7], e[6:0]);
    end
  endtask
  task automatic step(input string tag);
    logic [10:0] e;
    e = expect_out();
    @(posedge clk);
    if (c % FR == FR - 1) sh = bcd;
    bcnt = !blink ? 0 : (c % FR == FR - 1 ? bcnt + 1 : bcnt);
    c++;
    @(negedge clk);
    check_out(tag, e);
  endtask
  task automatic run(input int n, input string tag);
    for (int k = 0; k < n; k++) step(tag);
  endtask
  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    c = 0;
    sh = 12'h000;
    bcnt = 0;
  endtask
  initial begin
    dec = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
            7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
            7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
    bcd = 12'h255;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_out("reset_hold", {4'hF, 7'h7F});
    end
    release_reset();
    run(2 * FR + 4, "digits_255");
    #2 rst_n = 1'b0;
    #1 check_out("async_reset", {4'hF, 7'h7F});
    @(negedge clk);
    check_out("reset_again", {4'hF, 7'h7F});
    release_reset();
    bcd = 12'h007;
    blank_en = 1'b1;
    run(3 * FR, "blank_007");
    bcd = 12'h100;
    run(2 * FR, "blank_100");
    bcd = 12'h123;
    blank_en = 1'b0;
    run(FR - (c % FR), "align_123");
    run(FR + RD + 3, "frame_123");
    bcd = 12'h456;
    run(2 * FR, "frame_456");
    bcd = 12'h0A3;
    blank_en = 1'b1;
    run(2 * FR, "dash_0A3");
    bcd = 12'h042;
    blink = 1'b1;
    run(5 * FR, "blink_042");
    for (int k = 0; k < 8 * FR && !((bcnt / BF) % 2 == 1 && c % FR == 10); k++) step("blink_seek");
    checks++;
    assert ((bcnt / BF) % 2 == 1 && c % FR == 10) else begin
      failures++;
      $error("FAIL blink_dark_timeout bcnt=%0d c=%0d expected dark frame", bcnt, c);
    end
    blink = 1'b0;
    run(FR + 8, "blink_release");
    for (int r = 0; r < 30; r++) begin
      bcd = 12'($urandom);
      blank_en = 1'($urandom);
      blink = ($urandom % 3) == 0;
      run($urandom_range(5, 70), "random");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
